aes_round_key_sequencer: RTL
============================

Name: aes_round_key_sequencer

Overview:
Registered stage directly downstream of the combinational AES-128 key expander. It captures the 1408-bit expanded key and issues the eleven 128-bit round keys, one per valid/ready handshake, to the round datapath. Encrypt order is round 0 to 10; decrypt order is round 10 to 0. It decouples the wide expander output from the per-round pipeline and holds each round key stable under backpressure.

Parameters:
BLOCK_W, 128, round key width in bits
NUM_ROUNDS, 10, AES round count; number of round keys = NUM_ROUNDS+1
EXP_W, BLOCK_W*(NUM_ROUNDS+1) = 1408, expanded key width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
expanded_key  in  EXP_W  expander output; round r = expanded_key[EXP_W-1-BLOCK_W*r -: BLOCK_W], so round 0 (cipher key) is at the MSBs
key_load  in  1  capture expanded_key into the internal key register this cycle
start  in  1  begin a round-key sequence
decrypt  in  1  direction, sampled only when start is accepted (0 = encrypt, 1 = decrypt)
abort  in  1  terminate the current sequence
rk_ready  in  1  consumer can take round_key this cycle
rk_valid  out  1  round_key/round_num are valid
round_key  out  BLOCK_W  current round key
round_num  out  4  index of current round key (0..NUM_ROUNDS)
last_round  out  1  high with rk_valid when round_num is the final key of the sequence
busy  out  1  sequence in progress (ISSUE state)
done  out  1  one-cycle pulse after the final key transfers
key_loaded  out  1  key register holds a valid key since reset

Behaviour:
- Reset (n_rst=0, async): state=IDLE, key register=0, counter=0, dir=0, key_loaded=0. All outputs 0: rk_valid, round_key, round_num, last_round, busy, done.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: key_load=1 captures expanded_key and sets key_loaded=1 at the next edge. start is accepted only if key_loaded=1 and key_load=0 in the same cycle. A start in the same cycle as key_load is ignored, as is any start with no key loaded. On accept: dir<=decrypt, counter<=0 (encrypt) or NUM_ROUNDS (decrypt), state<=ISSUE.
- ISSUE: rk_valid=1, busy=1. round_key is selected by the registered counter from the registered key. round_num=counter. last_round=1 when counter=NUM_ROUNDS (encrypt) or counter=0 (decrypt).
- Transfer happens when rk_valid & rk_ready. On a non-last transfer, counter steps +1 (encrypt) or -1 (decrypt). On the last transfer, state goes to DONE. No wrap-around.
- Backpressure: while rk_ready=0, round_key, round_num and last_round hold constant.
- DONE: lasts one cycle. done=1, rk_valid=0, busy=0, then state returns to IDLE. start during DONE is ignored.
- Latency: start accepted at edge t gives rk_valid=1 from t+1. With rk_ready held at 1, 11 keys take 11 consecutive cycles and done follows in cycle t+12.
- key_load while in ISSUE or DONE is ignored; the key register is unchanged mid-sequence.
- abort=1 in ISSUE: state goes to IDLE at the next edge with no done pulse, and counter is left as-is. A transfer in the same cycle as abort still counts on the consumer side, but no further keys are issued. abort in IDLE or DONE has no effect; DONE still completes.
- Outside ISSUE: round_key=0, round_num=0, last_round=0.
- Async reset mid-sequence: everything returns to reset values immediately, including key_loaded=0.

Test Plan:
1. Reset then start with no key_load -> start ignored; rk_valid stays 0, key_loaded=0.
2. key_load with expanded key for cipher key 000102030405060708090a0b0c0d0e0f, then start with decrypt=0 and rk_ready=1 -> 11 consecutive valid cycles. Round 0 = 000102030405060708090a0b0c0d0e0f, round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5 with last_round=1; done one cycle later.
3. Same key, decrypt=1 -> first key 13111d7fe3944a17f307a78b4d2b30c5 with round_num=10; last is round 0 (000102…0f) with last_round=1; then done.
4. Backpressure: rk_ready=0 for 3 cycles at round 4 -> round_key and round_num=4 held; sequence resumes at round 5 with no key skipped or duplicated.
5. key_load of a new expanded key (cipher key 5468617473206D79204B756E67204675) during ISSUE -> current sequence still issues the old keys. After done, a fresh load plus start issues round 1 = e232fcf191129188b159e4e6d679a293.
6. abort at round 6 -> rk_valid drops next cycle, no done pulse; a new start then begins again at round 0. Also assert n_rst low mid-sequence -> all outputs 0 and key_loaded=0 immediately.

Source files
------------

// File: rtl/aes_round_key_sequencer.sv
// Round-key sequencer: latches the full AES-128 key schedule and hands out
// one 128-bit round key per valid/ready transfer, forward for encrypt and
// backward for decrypt.
module aes_round_key_sequencer #(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [BLOCK_W*(NUM_ROUNDS+1)-1:0]   expanded_key,
  input  logic                                key_load,
  input  logic                                start,
  input  logic                                decrypt,
  input  logic                                abort,
  input  logic                                rk_ready,
  output logic                                rk_valid,
  output logic [BLOCK_W-1:0]                  round_key,
  output logic [3:0]                          round_num,
  output logic                                last_round,
  output logic                                busy,
  output logic                                done,
  output logic                                key_loaded
);

  localparam int unsigned EXP_W = BLOCK_W * (NUM_ROUNDS + 1);
  localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e             state_q, state_d;
  logic [EXP_W-1:0]   key_q, key_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               key_loaded_q, key_loaded_d;

  logic [BLOCK_W-1:0] rk_sel;
  logic               is_last;

  // Round r lives at the r-th BLOCK_W slice counted down from the MSB end.
  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= int'(NUM_ROUNDS); r++) begin
      if (cnt_q == 4'(r)) begin
        rk_sel = key_q[EXP_W-1-BLOCK_W*r -: BLOCK_W];
      end
    end
  end

  // Final key of the sequence depends on the direction latched at start.
  always_comb begin
    is_last = dir_q ? (cnt_q == 4'd0) : (cnt_q == LastIdx);
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    key_loaded_d = key_loaded_q;
    rk_valid     = 1'b0;
    round_key    = '0;
    round_num    = 4'd0;
    last_round   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A load in the same cycle wins over start, so a sequence never
        // launches on a half-updated key register.
        if (key_load) begin
          key_d        = expanded_key;
          key_loaded_d = 1'b1;
        end else if (start && key_loaded_q) begin
          dir_d   = decrypt;
          cnt_d   = decrypt ? LastIdx : 4'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        rk_valid   = 1'b1;
        busy       = 1'b1;
        round_key  = rk_sel;
        round_num  = cnt_q;
        last_round = is_last;
        if (abort) begin
          state_d = StIdle;
        end else if (rk_ready) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            cnt_d = dir_q ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and key storage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      key_q        <= '0;
      cnt_q        <= 4'd0;
      dir_q        <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  assign key_loaded = key_loaded_q;

endmodule
